// File: rtl/uart_rx.sv
// UART receive engine: 2-flop synchronised line, mid-bit sampling at a 32/16/8-clock
// bit period, optional parity, and one-cycle valid / parity-error / stop-error strobes.
module uart_rx #(
  parameter int PARITY_EN = 1,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        clk_rate,
  input  logic              par_typ,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              par_err,
  output logic              stop_err,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic              meta_q, meta_d;
  logic              rx_s_q, rx_s_d;
  logic              hist_q, hist_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        rate_q, rate_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              par_err_q, par_err_d;
  logic              stop_err_q, stop_err_d;
  logic              busy_q, busy_d;

  logic              start_edge;
  logic [4:0]        last_cnt;
  logic [4:0]        half_cnt;

  // Period terminal counts come from the rate latched at the start edge, never the live input.
  always_comb begin
    last_cnt = 5'd7;
    half_cnt = 5'd3;
    case (rate_q)
      2'b00: begin
        last_cnt = 5'd31;
        half_cnt = 5'd15;
      end
      2'b01: begin
        last_cnt = 5'd15;
        half_cnt = 5'd7;
      end
      default: begin
        last_cnt = 5'd7;
        half_cnt = 5'd3;
      end
    endcase
  end

  assign start_edge = hist_q & ~rx_s_q;

  always_comb begin
    state_d    = state_q;
    meta_d     = rx_in;
    rx_s_d     = meta_q;
    hist_d     = rx_s_q;
    cnt_d      = cnt_q + 5'd1;
    rate_d     = rate_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    par_err_d  = 1'b0;
    stop_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        if (start_edge && (clk_rate != 2'b11)) begin
          rate_d    = clk_rate;
          par_bad_d = 1'b0;
          state_d   = START;
        end
      end

      START: begin
        if (cnt_q == half_cnt) begin
          cnt_d = 5'd0;
          if (!rx_s_q) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end

      // One full period after mid-start lands in mid-bit, so every later sample is at P-1.
      DATA: begin
        if (cnt_q == last_cnt) begin
          cnt_d   = 5'd0;
          shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (cnt_q == last_cnt) begin
          cnt_d     = 5'd0;
          par_bad_d = rx_s_q ^ (^shift_q) ^ par_typ;
          state_d   = STOP;
        end
      end

      // Leaving at mid-stop gives half a bit of margin to catch a back-to-back start edge.
      STOP: begin
        if (cnt_q == last_cnt) begin
          cnt_d      = 5'd0;
          rx_data_d  = shift_q;
          stop_err_d = ~rx_s_q;
          par_err_d  = par_bad_q;
          rx_valid_d = rx_s_q & ~par_bad_q;
          state_d    = IDLE;
        end
      end

      default: begin
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      meta_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      hist_q     <= 1'b1;
      cnt_q      <= 5'd0;
      rate_q     <= 2'b00;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      rx_s_q     <= rx_s_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      rate_q     <= rate_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign par_err  = par_err_q;
  assign stop_err = stop_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built frames driven bit by bit, strobes tallied
// by a negedge monitor and compared against hand-computed expectations.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] clk_rate = 2'b01;
  logic       par_typ = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       par_err;
  logic       stop_err;
  logic       busy;

  uart_rx #(.PARITY_EN(1), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_rate (clk_rate),
    .par_typ  (par_typ),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .par_err  (par_err),
    .stop_err (stop_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int e0 = 0;
  int valid_cnt = 0;
  int perr_cnt = 0;
  int serr_cnt = 0;
  int busy_cnt = 0;
  int overlap_cnt = 0;
  int valid_cyc = 0;
  int v0, p0, s0, b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe tally sampled mid-cycle; counts are cycles high, so a 1-cycle pulse adds exactly 1.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (par_err) perr_cnt++;
    if (stop_err) serr_cnt++;
    if (busy) busy_cnt++;
    if (rx_valid && (par_err || stop_err)) overlap_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    v0 = valid_cnt;
    p0 = perr_cnt;
    s0 = serr_cnt;
    b0 = busy_cnt;
  endtask

  // Drives one frame with every bit lasting per clocks; optionally changes clk_rate at data bit sw_bit.
  task automatic apply_stimulus(input logic [7:0] d, input logic p, input logic s, input int per,
                                input int sw_bit, input logic [1:0] sw_rate);
    e0 = cyc;
    rx_in = 1'b0;
    repeat (per) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == sw_bit) clk_rate = sw_rate;
      repeat (per) @(posedge clk);
      #1;
    end
    rx_in = p;
    repeat (per) @(posedge clk);
    #1;
    rx_in = s;
    repeat (per) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle_cycles(3);
    check_output("rst_rx_data", 32'(rx_data), 32'h00);
    check_output("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_output("rst_par_err", 32'(par_err), 32'h0);
    check_output("rst_stop_err", 32'(stop_err), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    idle_cycles(4);

    // P=16, even parity, 0xA5 has four ones -> parity 0
    clk_rate = 2'b01;
    par_typ = 1'b0;
    snapshot();
    apply_stimulus(8'hA5, 1'b0, 1'b1, 16, -1, 2'b00);
    check_output("a5_valid_time", 32'(valid_cyc), 32'(e0 + 3 + 8 + 160));
    check_output("a5_rx_data", 32'(rx_data), 32'hA5);
    check_output("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_output("a5_perr_cnt", 32'(perr_cnt - p0), 32'd0);
    check_output("a5_serr_cnt", 32'(serr_cnt - s0), 32'd0);

    // P=32, odd parity, 0x3C has four ones -> correct parity is 1, send 0
    clk_rate = 2'b00;
    par_typ = 1'b1;
    idle_cycles(4);
    snapshot();
    apply_stimulus(8'h3C, 1'b0, 1'b1, 32, -1, 2'b00);
    check_output("3c_perr_cnt", 32'(perr_cnt - p0), 32'd1);
    check_output("3c_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_output("3c_serr_cnt", 32'(serr_cnt - s0), 32'd0);
    check_output("3c_rx_data", 32'(rx_data), 32'h3C);

    // P=8, 0xFF with low stop then a long break
    clk_rate = 2'b10;
    par_typ = 1'b0;
    idle_cycles(4);
    snapshot();
    apply_stimulus(8'hFF, 1'b0, 1'b0, 8, -1, 2'b00);
    idle_cycles(24);
    check_output("brk_serr_cnt", 32'(serr_cnt - s0), 32'd1);
    check_output("brk_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_output("brk_perr_cnt", 32'(perr_cnt - p0), 32'd0);
    check_output("brk_rx_data", 32'(rx_data), 32'hFF);
    check_output("brk_busy", 32'(busy), 32'h0);
    b0 = busy_cnt;
    rx_in = 1'b1;
    idle_cycles(20);
    check_output("brk_no_busy", 32'(busy_cnt - b0), 32'd0);
    check_output("brk_serr_once", 32'(serr_cnt - s0), 32'd1);

    // 3-clock glitch at P=16: busy for P/2 cycles only
    clk_rate = 2'b01;
    snapshot();
    rx_in = 1'b0;
    idle_cycles(3);
    rx_in = 1'b1;
    idle_cycles(30);
    check_output("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
    check_output("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_output("glitch_err_cnt", 32'((perr_cnt - p0) + (serr_cnt - s0)), 32'd0);

    // Back-to-back at P=8; rate change during frame 2 only takes effect for frame 3
    clk_rate = 2'b10;
    idle_cycles(4);
    snapshot();
    apply_stimulus(8'h00, 1'b0, 1'b1, 8, -1, 2'b00);
    check_output("b2b_f1_data", 32'(rx_data), 32'h00);
    apply_stimulus(8'h55, 1'b0, 1'b1, 8, 3, 2'b00);
    check_output("b2b_f2_data", 32'(rx_data), 32'h55);
    apply_stimulus(8'h81, 1'b0, 1'b1, 32, -1, 2'b00);
    check_output("b2b_f3_data", 32'(rx_data), 32'h81);
    check_output("b2b_f3_time", 32'(valid_cyc), 32'(e0 + 3 + 16 + 320));
    check_output("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd3);
    check_output("b2b_err_cnt", 32'((perr_cnt - p0) + (serr_cnt - s0)), 32'd0);

    // Reset during DATA of 0x5A (bits 0..2 = 0,1,0), then a clean 0x12
    clk_rate = 2'b10;
    idle_cycles(4);
    snapshot();
    rx_in = 1'b0;
    idle_cycles(8);
    rx_in = 1'b0;
    idle_cycles(8);
    rx_in = 1'b1;
    idle_cycles(8);
    rx_in = 1'b0;
    idle_cycles(3);
    rst = 1'b0;
    rx_in = 1'b1;
    #1;
    check_output("mid_rst_rx_data", 32'(rx_data), 32'h00);
    check_output("mid_rst_busy", 32'(busy), 32'h0);
    check_output("mid_rst_strobes", 32'({rx_valid, par_err, stop_err}), 32'h0);
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(4);
    apply_stimulus(8'h12, 1'b0, 1'b1, 8, -1, 2'b00);
    check_output("post_rst_rx_data", 32'(rx_data), 32'h12);
    check_output("post_rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_output("post_rst_err_cnt", 32'((perr_cnt - p0) + (serr_cnt - s0)), 32'd0);

    // Reserved rate: frames ignored entirely
    clk_rate = 2'b11;
    idle_cycles(4);
    snapshot();
    apply_stimulus(8'h3C, 1'b0, 1'b1, 8, -1, 2'b11);
    apply_stimulus(8'h12, 1'b0, 1'b1, 16, -1, 2'b11);
    idle_cycles(10);
    check_output("rsv_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    check_output("rsv_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_output("rsv_err_cnt", 32'((perr_cnt - p0) + (serr_cnt - s0)), 32'd0);
    check_output("rsv_rx_data", 32'(rx_data), 32'h12);

    check_output("valid_err_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
